// File: rtl/sprite_line_engine.sv
// Sprite line engine: holds a 32-entry sprite table, scans it during hblank into
// per-line slots, and reports the winning sprite and texel coordinate per pixel.
module sprite_line_engine #(
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_SIZE     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sprite_sel,
  input  logic [9:0] sprite_x,
  input  logic [8:0] sprite_y,
  input  logic       sprite_pos,
  input  logic       sprite_attr,
  input  logic       sprite_vis,
  input  logic       line_start,
  input  logic [8:0] next_line,
  input  logic [9:0] hcount,
  input  logic       display_en,
  output logic       hit,
  output logic [4:0] hit_id,
  output logic [3:0] hit_row,
  output logic [3:0] hit_col,
  output logic       overflow,
  output logic       scan_busy
);

  localparam logic [10:0] SIZE11   = 11'(SPR_SIZE);
  localparam logic [3:0]  TEX_MAX  = 4'(SPR_SIZE - 1);
  localparam logic [3:0]  SLOT_MAX = 4'(MAX_PER_LINE);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] attr;
    logic       vis;
  } entry_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] id;
    logic [9:0] x;
    logic [1:0] attr;
    logic [3:0] row;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  entry_t     spr_table [32];
  slot_t      pend      [MAX_PER_LINE];
  slot_t      slots     [MAX_PER_LINE];
  state_t     state;
  logic [8:0] line_q;
  logic [4:0] idx;
  logic [3:0] pend_count;
  logic       pend_ovf;

  entry_t     cur;
  logic       scan_match;
  logic [3:0] scan_row;

  // Each strobe touches only its own field, so simultaneous strobes compose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) spr_table[i] <= '0;
    end else begin
      if (sprite_pos) begin
        spr_table[sprite_sel].x <= sprite_x;
        spr_table[sprite_sel].y <= sprite_y;
      end
      if (sprite_attr) spr_table[sprite_sel].attr <= sprite_x[1:0];
      if (sprite_vis)  spr_table[sprite_sel].vis  <= sprite_x[0];
    end
  end

  assign cur        = spr_table[idx];
  assign scan_match = cur.vis && ({2'b0, line_q} >= {2'b0, cur.y}) &&
                      ({2'b0, line_q} < ({2'b0, cur.y} + SIZE11));
  assign scan_row   = 4'(line_q - cur.y);

  // A line_start in any state restarts the scan; only COMMIT touches the active slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      line_q     <= '0;
      idx        <= '0;
      pend_count <= '0;
      pend_ovf   <= 1'b0;
      overflow   <= 1'b0;
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        pend[k]  <= '0;
        slots[k] <= '0;
      end
    end else if (line_start) begin
      state      <= SCAN;
      line_q     <= next_line;
      idx        <= '0;
      pend_count <= '0;
      pend_ovf   <= 1'b0;
      for (int k = 0; k < MAX_PER_LINE; k++) pend[k].valid <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (scan_match) begin
            if (pend_count < SLOT_MAX) begin
              for (int k = 0; k < MAX_PER_LINE; k++) begin
                if (4'(k) == pend_count) pend[k] <= {1'b1, idx, cur.x, cur.attr, scan_row};
              end
              pend_count <= pend_count + 4'd1;
            end else begin
              pend_ovf <= 1'b1;
            end
          end
          idx <= idx + 5'd1;
          if (idx == 5'd31) state <= COMMIT;
        end
        COMMIT: begin
          for (int k = 0; k < MAX_PER_LINE; k++) slots[k] <= pend[k];
          overflow <= pend_ovf;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign scan_busy = (state != IDLE);

  logic       px_hit;
  logic [4:0] px_id;
  logic [3:0] px_row;
  logic [3:0] px_col;
  logic [3:0] col_raw;

  // Walk slots from highest to lowest so the lowest matching slot has the final say.
  always_comb begin
    px_hit  = 1'b0;
    px_id   = '0;
    px_row  = '0;
    px_col  = '0;
    col_raw = '0;
    for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
      if (slots[k].valid && ({1'b0, hcount} >= {1'b0, slots[k].x}) &&
          ({1'b0, hcount} < ({1'b0, slots[k].x} + SIZE11))) begin
        col_raw = 4'(hcount - slots[k].x);
        px_hit  = 1'b1;
        px_id   = slots[k].id;
        px_col  = slots[k].attr[0] ? (TEX_MAX - col_raw) : col_raw;
        px_row  = slots[k].attr[1] ? (TEX_MAX - slots[k].row) : slots[k].row;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit     <= 1'b0;
      hit_id  <= '0;
      hit_row <= '0;
      hit_col <= '0;
    end else if (display_en && px_hit) begin
      hit     <= 1'b1;
      hit_id  <= px_id;
      hit_row <= px_row;
      hit_col <= px_col;
    end else begin
      hit     <= 1'b0;
      hit_id  <= '0;
      hit_row <= '0;
      hit_col <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed scenarios plus randomized tables checked
// against a list-based model of which sprites land on each line.
module tb_sprite_line_engine;

  localparam int MAX = 4;
  localparam int SPR = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] sprite_sel = '0;
  logic [9:0] sprite_x = '0;
  logic [8:0] sprite_y = '0;
  logic       sprite_pos = 1'b0, sprite_attr = 1'b0, sprite_vis = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] next_line = '0;
  logic [9:0] hcount = '0;
  logic       display_en = 1'b0;
  logic       hit;
  logic [4:0] hit_id;
  logic [3:0] hit_row, hit_col;
  logic       overflow, scan_busy;

  int checks = 0;
  int errors = 0;

  int tx[32], ty[32], tattr[32], tvis[32];
  int m_ids[$], m_x[$], m_attr[$], m_row[$];
  bit m_ovf;

  sprite_line_engine #(.MAX_PER_LINE(MAX), .SPR_SIZE(SPR)) dut (
    .clk(clk), .reset(reset), .sprite_sel(sprite_sel), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_pos(sprite_pos), .sprite_attr(sprite_attr),
    .sprite_vis(sprite_vis), .line_start(line_start), .next_line(next_line),
    .hcount(hcount), .display_en(display_en), .hit(hit), .hit_id(hit_id),
    .hit_row(hit_row), .hit_col(hit_col), .overflow(overflow), .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model: every visible sprite covering the line, in table order, first MAX kept.
  function automatic void model_line(input int line);
    m_ids.delete(); m_x.delete(); m_attr.delete(); m_row.delete();
    m_ovf = 0;
    for (int i = 0; i < 32; i++) begin
      if (tvis[i] != 0 && line >= ty[i] && line < ty[i] + SPR) begin
        if (m_ids.size() < MAX) begin
          m_ids.push_back(i); m_x.push_back(tx[i]);
          m_attr.push_back(tattr[i]); m_row.push_back(line - ty[i]);
        end else m_ovf = 1;
      end
    end
  endfunction

  function automatic logic [13:0] model_pixel(input int h, input bit de);
    int c, r;
    if (!de) return '0;
    for (int s = 0; s < m_ids.size(); s++) begin
      if (h >= m_x[s] && h < m_x[s] + SPR) begin
        c = h - m_x[s];
        r = m_row[s];
        if (m_attr[s] % 2 == 1) c = SPR - 1 - c;
        if (m_attr[s] >= 2) r = SPR - 1 - r;
        return {1'b1, 5'(m_ids[s]), 4'(r), 4'(c)};
      end
    end
    return '0;
  endfunction

  function automatic logic [13:0] pack(input logic h, input logic [4:0] id,
                                       input logic [3:0] r, input logic [3:0] c);
    return {h, id, r, c};
  endfunction

  task automatic write_pos(input int sel, input int x, input int y);
    @(negedge clk);
    sprite_sel = 5'(sel); sprite_x = 10'(x); sprite_y = 9'(y); sprite_pos = 1'b1;
    @(negedge clk);
    sprite_pos = 1'b0;
    tx[sel] = x; ty[sel] = y;
  endtask

  task automatic write_attr(input int sel, input int a);
    @(negedge clk);
    sprite_sel = 5'(sel); sprite_x = 10'(a); sprite_attr = 1'b1;
    @(negedge clk);
    sprite_attr = 1'b0;
    tattr[sel] = a;
  endtask

  task automatic write_vis(input int sel, input int v);
    @(negedge clk);
    sprite_sel = 5'(sel); sprite_x = 10'(v); sprite_vis = 1'b1;
    @(negedge clk);
    sprite_vis = 1'b0;
    tvis[sel] = v % 2;
  endtask

  task automatic do_line(input int line);
    int n;
    @(negedge clk);
    line_start = 1'b1; next_line = 9'(line);
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (scan_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL scan_done line %0d: scan_busy %b after %0d clocks, want 0", line, scan_busy, n);
    end
    model_line(line);
  endtask

  task automatic sample_pixel(input int h, input bit de);
    @(negedge clk);
    hcount = 10'(h); display_en = de;
    @(negedge clk);
    display_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    sprite_sel = 5'd3; sprite_x = 10'd1; sprite_vis = 1'b1;
    @(negedge clk);
    checks++;
    if ({hit, hit_id, hit_row, hit_col, overflow, scan_busy} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0000",
               {hit, hit_id, hit_row, hit_col, overflow, scan_busy});
    end
    sprite_vis = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (scan_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b want 0", scan_busy);
    end
    do_line(0);
    sample_pixel(0, 1'b1);
    checks++;
    if ({hit, overflow} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_table: hit/overflow %b%b want 00", hit, overflow);
    end
  endtask

  task automatic test_basic_hit();
    write_pos(2, 100, 50);
    write_vis(2, 1);
    do_line(55);
    sample_pixel(100, 1'b1);
    checks++;
    if (pack(hit, hit_id, hit_row, hit_col) !== {1'b1, 5'd2, 4'd5, 4'd0}) begin
      errors++;
      $display("[TB] FAIL basic_h100: got %h want %h", pack(hit, hit_id, hit_row, hit_col),
               {1'b1, 5'd2, 4'd5, 4'd0});
    end
    sample_pixel(115, 1'b1);
    checks++;
    if (pack(hit, hit_id, hit_row, hit_col) !== {1'b1, 5'd2, 4'd5, 4'd15}) begin
      errors++;
      $display("[TB] FAIL basic_h115: got %h want %h", pack(hit, hit_id, hit_row, hit_col),
               {1'b1, 5'd2, 4'd5, 4'd15});
    end
    sample_pixel(116, 1'b1);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_h116: hit %b want 0", hit);
    end
  endtask

  task automatic test_priority_flip();
    write_pos(1, 200, 10);
    write_pos(7, 200, 10);
    write_attr(1, 3);
    write_vis(1, 1);
    write_vis(7, 1);
    do_line(10);
    sample_pixel(203, 1'b1);
    checks++;
    if (pack(hit, hit_id, hit_row, hit_col) !== {1'b1, 5'd1, 4'd15, 4'd12}) begin
      errors++;
      $display("[TB] FAIL prio_flip: got %h want %h", pack(hit, hit_id, hit_row, hit_col),
               {1'b1, 5'd1, 4'd15, 4'd12});
    end
    sample_pixel(203, 1'b0);
    checks++;
    if (pack(hit, hit_id, hit_row, hit_col) !== 14'h0) begin
      errors++;
      $display("[TB] FAIL display_off: got %h want 0", pack(hit, hit_id, hit_row, hit_col));
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 6; k++) begin
      write_pos(k, 400 + 20 * k, 20);
      write_vis(k, 1);
    end
    do_line(20);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: got %b want 1", overflow);
    end
    for (int k = 0; k < 6; k++) begin
      sample_pixel(400 + 20 * k + 1, 1'b1);
      checks++;
      if (hit !== (k < MAX) || (k < MAX && hit_id !== 5'(k))) begin
        errors++;
        $display("[TB] FAIL overflow_slot%0d: hit %b id %0d want hit %0d id %0d",
                 k, hit, hit_id, (k < MAX), (k < MAX) ? k : 0);
      end
    end
    do_line(300);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    line_start = 1'b1; next_line = 9'd10;
    @(negedge clk);
    line_start = 1'b0;
    repeat (9) @(negedge clk);
    line_start = 1'b1; next_line = 9'd20;
    @(negedge clk);
    line_start = 1'b0;
    repeat (32) @(negedge clk);
    checks++;
    if ({scan_busy, overflow} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL restart_pre_commit: busy/ovf %b%b want 10", scan_busy, overflow);
    end
    @(negedge clk);
    checks++;
    if ({scan_busy, overflow} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL restart_commit: busy/ovf %b%b want 01", scan_busy, overflow);
    end
    model_line(20);
    sample_pixel(401, 1'b1);
    checks++;
    if (pack(hit, hit_id, hit_row, hit_col) !== {1'b1, 5'd0, 4'd0, 4'd1}) begin
      errors++;
      $display("[TB] FAIL restart_second: got %h want %h", pack(hit, hit_id, hit_row, hit_col),
               {1'b1, 5'd0, 4'd0, 4'd1});
    end
    sample_pixel(203, 1'b1);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_first_gone: hit %b want 0", hit);
    end
  endtask

  task automatic test_edge();
    write_pos(9, 1020, 0);
    write_vis(9, 1);
    do_line(0);
    for (int h = 1020; h < 1024; h++) begin
      sample_pixel(h, 1'b1);
      checks++;
      if (pack(hit, hit_id, hit_row, hit_col) !== {1'b1, 5'd9, 4'd0, 4'(h - 1020)}) begin
        errors++;
        $display("[TB] FAIL edge_h%0d: got %h want %h", h, pack(hit, hit_id, hit_row, hit_col),
                 {1'b1, 5'd9, 4'd0, 4'(h - 1020)});
      end
    end
    for (int h = 0; h < 12; h++) begin
      sample_pixel(h, 1'b1);
      checks++;
      if (hit !== 1'b0) begin
        errors++;
        $display("[TB] FAIL edge_nowrap_h%0d: hit %b want 0", h, hit);
      end
    end
  endtask

  task automatic test_random();
    int line, s, h;
    bit de;
    logic [13:0] exp;
    for (int round = 0; round < 8; round++) begin
      for (int w = 0; w < 6; w++) begin
        s = $urandom_range(0, 31);
        write_pos(s, $urandom_range(0, 1023), $urandom_range(0, 40));
        write_attr(s, $urandom_range(0, 3));
        write_vis(s, $urandom_range(0, 3) != 0 ? 1 : 0);
      end
      line = $urandom_range(0, 45);
      do_line(line);
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("[TB] FAIL rand_ovf line %0d: got %b want %b", line, overflow, m_ovf);
      end
      for (int p = 0; p < 8; p++) begin
        s = $urandom_range(0, 31);
        h = tx[s] + $urandom_range(0, 17) - 1;
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        de = ($urandom_range(0, 7) != 0);
        exp = model_pixel(h, de);
        sample_pixel(h, de);
        checks++;
        if (pack(hit, hit_id, hit_row, hit_col) !== exp) begin
          errors++;
          $display("[TB] FAIL rand_pix line %0d h %0d: got %h want %h", line, h,
                   pack(hit, hit_id, hit_row, hit_col), exp);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tx[i] = 0; ty[i] = 0; tattr[i] = 0; tvis[i] = 0;
    end
    test_reset();
    test_basic_hit();
    test_priority_flip();
    test_overflow();
    test_restart();
    test_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
